// File: rtl/ram8_ctrl_pkg.sv
// rtl/ram8_ctrl_pkg.sv - shared state encoding and default geometry for the RAM8 access controller
package ram8_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;
    localparam logic [15:0] DEFAULT_INIT_VALUE = 16'h0000;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
// A lone requester always wins; on a tie the client that was not granted last wins.
module rr_arbiter2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic gnt_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_o = ~last_i;
        end else begin
            gnt_o = req1_i;
        end
    end

endmodule

// File: rtl/ram8_arbiter.sv
// rtl/ram8_arbiter.sv - RAM8 init sweep plus two-client round-robin single-word access controller
// Sole driver of the RAM8 r/w/addr/D pins; every output comes straight from a flop.
module ram8_arbiter
    import ram8_ctrl_pkg::*;
#(
    parameter int                DATA_W     = DEFAULT_DATA_W,
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(DEFAULT_INIT_VALUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_r,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q,
    output logic              init_done,
    output logic              busy
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] SWEEP_END = DEPTH[ADDR_W:0];

    state_e              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic                last_q;
    logic                gnt_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ram_r_q;
    logic                ram_w_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_d_q;
    logic                init_done_q;
    logic                busy_q;

    logic                arb_valid;
    logic                arb_gnt;
    logic                sel_we_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;

    rr_arbiter2 u_rr (
        .req0_i  (req0),
        .req1_i  (req1),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        sel_we_d    = arb_gnt ? we1    : we0;
        sel_addr_d  = arb_gnt ? addr1  : addr0;
        sel_wdata_d = arb_gnt ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata_q     <= '0;
            ram_r_q     <= 1'b0;
            ram_w_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The counter runs one past the last word so address DEPTH-1 gets a full write cycle.
                    if (cnt_q == SWEEP_END) begin
                        state_q     <= ST_IDLE;
                        ram_w_q     <= 1'b0;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        ram_w_q    <= 1'b1;
                        ram_r_q    <= 1'b0;
                        ram_addr_q <= cnt_q[ADDR_W-1:0];
                        ram_d_q    <= INIT_VALUE;
                        cnt_q      <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_q    <= ST_ACCESS;
                        gnt_q      <= arb_gnt;
                        ram_w_q    <= sel_we_d;
                        ram_r_q    <= ~sel_we_d;
                        ram_addr_q <= sel_addr_d;
                        ram_d_q    <= sel_wdata_d;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (ram_r_q) begin
                        rdata_q <= ram_q;
                    end
                    ack0_q  <= ~gnt_q;
                    ack1_q  <= gnt_q;
                    ram_r_q <= 1'b0;
                    ram_w_q <= 1'b0;
                    last_q  <= gnt_q;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata     = rdata_q;
    assign ram_r     = ram_r_q;
    assign ram_w     = ram_w_q;
    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule
